// File: rtl/bgr_gray_stage.sv
// BMP pixel stage: forwards header bytes to the output RAM, converts each B,G,R triplet to luma
// and writes the gray value into all three channel bytes. Define GRAY_ROUND_EN for round-to-nearest luma.
module bgr_gray_stage #(
  parameter int BYTE_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 20,
  parameter int HEADER_SIZE = 54,
  parameter int TOTAL_SIZE  = 786486
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] in_byte,
  output logic                  in_ready,
  output logic                  RAM_valid,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic [BYTE_WIDTH-1:0] RAM_D,
  output logic                  done
);

  localparam int ACC_W  = 2 * BYTE_WIDTH;
  localparam int HCNT_W = $clog2(HEADER_SIZE + 1);

  typedef enum logic [2:0] {
    S_HDR, S_PB, S_PG, S_PR, S_E0, S_E1, S_E2, S_FIN
  } state_e;

  state_e                  state_q, state_d;
  logic [HCNT_W-1:0]       hcnt_q, hcnt_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_WIDTH-1:0]   b_q, b_d;
  logic [BYTE_WIDTH-1:0]   g_q, g_d;
  logic [BYTE_WIDTH-1:0]   gray_q, gray_d;
  logic                    hdr_wr_q, hdr_wr_d;
  logic [BYTE_WIDTH-1:0]   hdr_data_q, hdr_data_d;

  logic                    accept;
  logic                    pix_wr;
  logic [ACC_W-1:0]        acc;

  // Luma of the pixel whose R byte is on in_byte this cycle; coefficients sum to 256.
  always_comb begin
    acc = (ACC_W'(77)  * ACC_W'(in_byte))
        + (ACC_W'(150) * ACC_W'(g_q))
        + (ACC_W'(29)  * ACC_W'(b_q));
`ifdef GRAY_ROUND_EN
    acc = acc + ACC_W'(128);
`else
    acc = acc + ACC_W'(0);
`endif
  end

  assign in_ready  = (state_q == S_HDR) || (state_q == S_PB) ||
                     (state_q == S_PG)  || (state_q == S_PR);
  assign accept    = in_valid && in_ready;
  assign pix_wr    = (state_q == S_E0) || (state_q == S_E1) || (state_q == S_E2);
  assign RAM_valid = hdr_wr_q || pix_wr;
  assign RAM_D     = pix_wr ? gray_q : hdr_data_q;
  assign RAM_addr  = wr_addr_q;
  assign done      = (state_q == S_FIN);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    b_d        = b_q;
    g_d        = g_q;
    gray_d     = gray_q;
    hdr_wr_d   = 1'b0;
    hdr_data_d = hdr_data_q;
    wr_addr_d  = RAM_valid ? wr_addr_q + 1'b1 : wr_addr_q;

    unique case (state_q)
      S_HDR: if (accept) begin
        hdr_wr_d   = 1'b1;
        hdr_data_d = in_byte;
        hcnt_d     = hcnt_q + 1'b1;
        if (hcnt_q == HCNT_W'(HEADER_SIZE - 1)) state_d = S_PB;
      end
      S_PB: if (accept) begin
        b_d     = in_byte;
        state_d = S_PG;
      end
      S_PG: if (accept) begin
        g_d     = in_byte;
        state_d = S_PR;
      end
      S_PR: if (accept) begin
        gray_d  = acc[ACC_W-1:BYTE_WIDTH];
        state_d = S_E0;
      end
      S_E0: state_d = S_E1;
      S_E1: state_d = S_E2;
      // Address after this write equal to the file size means the image is complete.
      S_E2: state_d = (wr_addr_q + 1'b1 == ADDR_WIDTH'(TOTAL_SIZE)) ? S_FIN : S_PB;
      S_FIN: state_d = S_FIN;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      hcnt_q     <= '0;
      wr_addr_q  <= '0;
      b_q        <= '0;
      g_q        <= '0;
      gray_q     <= '0;
      hdr_wr_q   <= 1'b0;
      hdr_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      wr_addr_q  <= wr_addr_d;
      b_q        <= b_d;
      g_q        <= g_d;
      gray_q     <= gray_d;
      hdr_wr_q   <= hdr_wr_d;
      hdr_data_q <= hdr_data_d;
    end
  end

endmodule

// File: tb/tb_bgr_gray_stage.sv
// Scoreboard bench for bgr_gray_stage: the driver pushes expected RAM writes (address, data,
// cycle) on each accepted byte, a negedge monitor pops and compares every write the DUT makes.
module tb_bgr_gray_stage;

  localparam int HDR = 54;
  localparam int TOT = 66;  // header plus four pixels

`ifdef GRAY_ROUND_EN
  localparam logic [7:0] GRAY_A = 8'h16;  // B=0x0A G=0x14 R=0x1E
  localparam logic [7:0] GRAY_R = 8'h4D;  // pure red
`else
  localparam logic [7:0] GRAY_A = 8'h15;
  localparam logic [7:0] GRAY_R = 8'h4C;
`endif
  localparam logic [7:0] GRAY_W = 8'hFF;  // white

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic        clk, rst_n, in_valid, in_ready, RAM_valid, done;
  logic [7:0]  in_byte, RAM_D;
  logic [19:0] RAM_addr;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  exp_addr = 0;

  bgr_gray_stage #(
    .BYTE_WIDTH(8), .ADDR_WIDTH(20), .HEADER_SIZE(HDR), .TOTAL_SIZE(TOT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .RAM_valid(RAM_valid), .RAM_addr(RAM_addr), .RAM_D(RAM_D), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && RAM_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_write_addr", RAM_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", RAM_addr, e.addr);
        check("wr_data", RAM_D, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push(input logic [7:0] d, input int c);
    wr_t e;
    e.addr = 20'(exp_addr);
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
    exp_addr++;
  endtask

  // kind: 0 header byte, 1 B or G byte, 2 R byte (three gray writes follow).
  task automatic send_byte(input logic [7:0] b, input int kind, input logic [7:0] gray);
    int n = 0;
    int a;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    a = cyc;
    if (kind == 0) push(b, a + 1);
    if (kind == 2) for (int k = 1; k <= 3; k++) push(gray, a + k);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_header();
    for (int i = 0; i < HDR; i++) send_byte(8'(i), 0, 8'h00);
  endtask

  task automatic send_pixel(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r,
                            input logic [7:0] gray, input int gap, input logic last);
    send_byte(b, 1, 8'h00);
    send_byte(g, 1, 8'h00);
    repeat (gap) @(negedge clk);
    send_byte(r, 2, gray);
    for (int k = 0; k < 3; k++) begin
      check("busy_in_ready", in_ready, 0);
      check("done_early", done, 0);
      @(negedge clk);
    end
    check("post_pixel_in_ready", in_ready, !last);
    check("done_after_pixel", done, last);
  endtask

  task automatic full_image();
    send_header();
    send_pixel(8'h0A, 8'h14, 8'h1E, GRAY_A, 0, 1'b0);
    send_pixel(8'h00, 8'h00, 8'hFF, GRAY_R, 0, 1'b0);
    send_pixel(8'hFF, 8'hFF, 8'hFF, GRAY_W, 0, 1'b0);
    send_pixel(8'h0A, 8'h14, 8'h1E, GRAY_A, 5, 1'b1);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_RAM_valid"}, RAM_valid, 0);
    check({tag, "_RAM_addr"}, RAM_addr, 0);
    check({tag, "_RAM_D"}, RAM_D, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    sb.delete();
    exp_addr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_RAM_valid", RAM_valid, 0);
    check("rst_RAM_addr", RAM_addr, 0);
    check("rst_RAM_D", RAM_D, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Run 1: complete image, then extra bytes must be refused.
    full_image();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'(8'hA0 + i);
      check("fin_in_ready", in_ready, 0);
      check("fin_done", done, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("fin_addr_held", RAM_addr, TOT);
    async_reset_check("rst_fin");

    // Run 2: reset after the first B byte, then a fresh image from offset 0.
    send_header();
    send_byte(8'h11, 1, 8'h00);
    async_reset_check("rst_mid");
    full_image();

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bgr_gray_stage.md
Name: bgr_gray_stage

Overview:
Pixel-processing stage directly downstream of the BMP byte loader. Consumes the loader's BMP byte stream in file order through a valid/ready handshake. Forwards the BMP header bytes unchanged to the output RAM write port. Converts each B,G,R pixel triplet to luma and writes the gray value into all three channel bytes; asserts done once the full image has been written.

Parameters:
BYTE_WIDTH, 8, byte width of stream and RAM data
ADDR_WIDTH, 20, RAM address width
HEADER_SIZE, 54, bytes forwarded unmodified before pixel data
TOTAL_SIZE, 786486, total BMP bytes (512x512x3 + 54); (TOTAL_SIZE-HEADER_SIZE) must be a multiple of 3, no row padding supported

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_byte valid
in_byte  input  BYTE_WIDTH  BMP byte, file order from offset 0
in_ready  output  1  stage accepts in_byte this cycle
RAM_valid  output  1  RAM write strobe
RAM_addr  output  ADDR_WIDTH  RAM byte address
RAM_D  output  BYTE_WIDTH  RAM write data
done  output  1  image fully written, sticky

Behaviour:
- Reset, asynchronous: all outputs 0, state HDR, byte counter 0, write address 0, B/G holding registers 0.
- A byte is accepted on a rising edge with in_valid && in_ready. in_ready is combinational from state only, never from in_valid.
- States:
  - HDR: in_ready=1. Each accepted byte is written the next cycle (RAM_valid=1, RAM_D=byte, RAM_addr=wr_addr). wr_addr then increments.
  - HDR exit: after byte HEADER_SIZE-1 is accepted, go to PB.
  - PB: in_ready=1. Accept byte into B_reg, go to PG. No write.
  - PG: in_ready=1. Accept byte into G_reg, go to PR. No write.
  - PR: in_ready=1. Accept R, compute gray combinationally, register it, go to E0.
  - E0/E1/E2: in_ready=0. One write per state, RAM_D=gray_reg, RAM_addr=wr_addr, wr_addr++. E2 goes to PB, or to FIN if wr_addr reaches TOTAL_SIZE.
  - FIN: in_ready=0, RAM_valid=0, done=1 until reset. Extra input bytes are ignored.
- Arithmetic: gray = (77*R + 150*G + 29*B) >> 8. Use a 16-bit unsigned accumulator; maximum 65280, so no overflow. Result is the low 8 bits.
- Latency:
  - Header byte: written 1 cycle after acceptance.
  - Pixel: writes in the 3 cycles after R is accepted.
  - Peak throughput: 1 pixel per 6 cycles.
- No write occurs in PB, PG or PR. RAM_valid is low in any cycle without a write.
- in_valid low mid-triplet: stay in the current state, partial B/G values held.
- in_valid low in HDR: no write in the following cycle.
- done: rises the cycle after the final E2 write.
- Reset mid-image: immediate return to HDR with counters cleared. The next accepted byte is treated as file offset 0.
- RAM_addr increments by exactly 1 per write and never wraps within TOTAL_SIZE.

Optional Feature:
GRAY_ROUND_EN
- Defined: gray = (77*R + 150*G + 29*B + 128) >> 8, round to nearest. Maximum sum 65408, still 16 bits.
- Undefined: truncating formula above. Ports and timing are identical either way.

Test Plan:
- HEADER_SIZE=54, 54 header bytes 0x00..0x35 with in_valid constant -> RAM writes addr 0..53, data equal to input, each 1 cycle after acceptance; state PB after byte 53.
- Pixel B=0x0A, G=0x14, R=0x1E -> three writes of 0x15 (0x16 with GRAY_ROUND_EN) at addr 54,55,56; in_ready=0 for exactly 3 cycles.
- Pixels (0,0,255) and (255,255,255) -> gray 0x4C (0x4D rounded) and 0xFF in both modes.
- in_valid deasserted 5 cycles between G and R -> no writes during the gap; result identical to the gap-free run.
- Small config TOTAL_SIZE=60 (2 pixels), full stream plus 4 extra bytes -> done rises the cycle after the addr 59 write; extra bytes see in_ready=0; no write beyond addr 59.
- rst_n pulsed low mid-pixel (after B accepted) -> outputs 0 asynchronously; a restarted stream produces the header at addr 0 and correct gray values.
